d_register: RTL and testbench



---
 rtl/d_register.sv | 59 +++++
 tb/tb_d_register.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/d_register.sv
// D-type storage register with complementary outputs, built from identical
// bit-slices that share one clock, one asynchronous clear and one load enable.

module d_register_slice #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic d,
    output logic q,
    output logic q_n
);

    // Q_N has its own flop so both outputs come straight from registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= RESET_BIT;
            q_n <= ~RESET_BIT;
        end else if (load) begin
            q   <= d;
            q_n <= ~d;
        end
    end

endmodule

module d_register #(
    parameter int                 WIDTH       = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
    parameter int                 PROP_DELAY  = 3
) (
    input  logic             MainClock,
    input  logic             Clear,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_N
);

    // The clock-to-output delay exists only in behavioural models; the
    // synthesised register has none.
    logic [31:0] unused_prop_delay;
    assign unused_prop_delay = PROP_DELAY;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        d_register_slice #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_slice (
            .clk  (MainClock),
            .rst  (Clear),
            .load (Load),
            .d    (D[i]),
            .q    (Q[i]),
            .q_n  (Q_N[i])
        );
    end

endmodule

// File: tb/tb_d_register.sv
// Bench for d_register: directed vector table, hand-written async-clear
// sequences and a randomized run against a cycle-level reference model.

module tb_d_register;

    localparam int W = 4;

    logic         MainClock = 1'b0;
    logic         Clear     = 1'b0;
    logic         Load      = 1'b0;
    logic [W-1:0] D         = '0;
    logic [W-1:0] Q;
    logic [W-1:0] Q_N;

    int total = 0;
    int bad   = 0;

    d_register #(
        .WIDTH       (W),
        .RESET_VALUE (4'h0),
        .PROP_DELAY  (3)
    ) dut (
        .MainClock (MainClock),
        .Clear     (Clear),
        .Load      (Load),
        .D         (D),
        .Q         (Q),
        .Q_N       (Q_N)
    );

    always #5 MainClock = ~MainClock;

    typedef struct {
        logic         clear;
        logic         load;
        logic [W-1:0] d;
        logic [W-1:0] exp_q;
    } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        vec_t         vecs [$];
        logic [W-1:0] model;
        logic [W-1:0] pre;

        // 1: asynchronous clear between edges, no edge needed
        @(negedge MainClock);
        #1 Clear = 1'b1;
        #1;
        chk("async_clear_q", Q, 4'h0);
        chk("async_clear_qn", Q_N, 4'hF);
        @(negedge MainClock);
        chk("clear_held_q", Q, 4'h0);
        Clear = 1'b0;
        model = 4'h0;

        // 2/3: directed table, one rising edge per record
        vecs.push_back('{1'b0, 1'b1, 4'hA, 4'hA});
        vecs.push_back('{1'b0, 1'b0, 4'h3, 4'hA});
        vecs.push_back('{1'b0, 1'b0, 4'hC, 4'hA});
        vecs.push_back('{1'b0, 1'b0, 4'h3, 4'hA});
        vecs.push_back('{1'b0, 1'b1, 4'h5, 4'h5});
        vecs.push_back('{1'b1, 1'b1, 4'h9, 4'h0});
        vecs.push_back('{1'b0, 1'b0, 4'h6, 4'h0});
        vecs.push_back('{1'b0, 1'b1, 4'hF, 4'hF});
        vecs.push_back('{1'b0, 1'b1, 4'h0, 4'h0});
        vecs.push_back('{1'b0, 1'b1, 4'hA, 4'hA});
        for (int i = 0; i < vecs.size(); i++) begin
            Clear = vecs[i].clear;
            Load  = vecs[i].load;
            D     = vecs[i].d;
            #1;
            // before the edge only Clear may move the output
            pre = vecs[i].clear ? 4'h0 : model;
            chk("vec_pre_edge", Q, pre);
            @(negedge MainClock);
            chk("vec_q", Q, vecs[i].exp_q);
            chk("vec_qn", Q_N, ~vecs[i].exp_q);
            model = vecs[i].exp_q;
        end
        Clear = 1'b0;

        // 4: clear pulse mid-cycle while Q=A, then load 7
        Load = 1'b0;
        #2 Clear = 1'b1;
        #1;
        chk("pulse_clear_q", Q, 4'h0);
        chk("pulse_clear_qn", Q_N, 4'hF);
        Clear = 1'b0;
        @(negedge MainClock);
        chk("after_pulse_hold", Q, 4'h0);
        Load = 1'b1;
        D    = 4'h7;
        @(negedge MainClock);
        chk("load_after_pulse", Q, 4'h7);

        // 5: clear together with a loading edge
        Load = 1'b1;
        D    = 4'hF;
        @(posedge MainClock);
        Clear = 1'b1;
        #1;
        chk("clear_vs_edge_q", Q, 4'h0);
        chk("clear_vs_edge_qn", Q_N, 4'hF);
        @(negedge MainClock);
        Clear = 1'b0;
        Load  = 1'b0;
        @(negedge MainClock);
        chk("after_release_q", Q, 4'h0);
        chk("after_release_qn", Q_N, 4'hF);
        model = 4'h0;

        // 6: random Clear/Load/D against the reference model
        for (int c = 0; c < 1000; c++) begin
            logic pulse;
            Clear = ($urandom_range(0, 9) == 0);
            Load  = $urandom_range(0, 1);
            D     = W'($urandom);
            pulse = !Clear && ($urandom_range(0, 9) == 0);
            if (Clear) model = 4'h0;
            if (pulse) begin
                #2 Clear = 1'b1;
                #1 Clear = 1'b0;
                model = 4'h0;
            end
            @(posedge MainClock);
            if (!Clear && Load) model = D;
            @(negedge MainClock);
            chk("rand_q", Q, model);
            chk("rand_qn", Q_N, ~model);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
